led_bar_meter: RTL and testbench
================================

// Module: led_bar_meter
// PURPOSE
//  Parametrised centre-zero LED bar graph for JSTK axis values (velocity/steering) on the Basys3 LEDs.
//  Successor to the fixed 8+8 LED comparator: generic width, LEDs per side, centre, dead-band and step.
//  Adds valid-qualified sampling, hysteresis against flicker, stale-input blanking and optional peak-hold.
//  Sits between the SPI joystick decoder and the board LED pins.
// PARAMETERS
//  IN_W        11    input sample width (unsigned)
//  N_SIDE      8     LEDs per direction; led_on is 2*N_SIDE wide
//  CENTRE      500   joystick rest value
//  DEADBAND    20    |v-CENTRE| <= DEADBAND lights nothing
//  STEP        60    counts per additional LED
//  HYST        10    counts a level must drop below its threshold before it falls
//  HOLD_CYC    50_000_000  peak-hold dwell, clk cycles (peak-hold build only)
//  DECAY_CYC   5_000_000   cycles per one-level peak decay (peak-hold build only)
//  TIMEOUT_CYC 100_000_000 cycles without in_valid before blanking; 0 = never blank
// PORTS
//  clk       in   1              system clock, all logic on rising edge
//  rst       in   1              asynchronous, active-low reset
//  in_valid  in   1              velocity qualifier, one-cycle strobe or level
//  velocity  in   IN_W           unsigned axis sample
//  led_on    out  2*N_SIDE       bar pattern to board LEDs
//  level     out  clog2(N_SIDE+1) current lit LED count (0..N_SIDE)
//  dir       out  1              1 = above CENTRE (low half), 0 = below CENTRE (high half)
// BEHAVIOUR
//  - Reset (rst=0, async): led_on=0, level=0, dir=0, all counters/peak cleared. Reset mid-update discards the pipeline.
//  - Stage 1 (edge where in_valid=1): capture dir=(velocity>CENTRE), mag=|velocity-CENTRE| in IN_W+1 bits, no wrap.
//  - Threshold thr(k)=DEADBAND+(k-1)*STEP, k=1..N_SIDE. up=#k with mag>thr(k); dn=#k with mag>thr(k)-HYST (clamp at 0).
//  - Stage 2: if dir differs from held dir and up>0: level=up, dir updated (no hysteresis across zero).
//    else if up>=level: level=up. else level=min(level,dn). up==0 with dn==0 -> level=0.
//  - Saturation: mag beyond thr(N_SIDE) gives level=N_SIDE; never exceeds N_SIDE.
//  - Latency: in_valid at edge t -> level/dir at t+1, led_on at t+2. in_valid=0: all outputs hold.
//  - Pattern: dir=1 lights led_on[N_SIDE-1 -: level] (fills from bit N_SIDE-1 down to bit 0);
//    dir=0 lights led_on[N_SIDE +: level] (fills from bit N_SIDE up). Opposite half always 0.
//  - Stale input: counter reset by every in_valid; reaching TIMEOUT_CYC forces level=0, led_on=0
//    (peak cleared) until next in_valid. in_valid on the terminal cycle wins over the timeout.
//  - mag exactly equal to thr(k) does not light LED k (strict greater-than).
// CONFIGURATION
//  LED_BAR_PEAK_HOLD_EN defined:
//   - peak register tracks max level in current dir; extra LED at peak position lit OR-ed into bar.
//   - new level>peak: peak=level, hold counter restarts. Hold expires -> peak decreases 1 per DECAY_CYC until =level.
//   - dir change or timeout: peak=level immediately, counters cleared.
//  LED_BAR_PEAK_HOLD_EN undefined: no peak logic or counters; led_on is the plain bar.
// TESTING
//  (small params: HOLD_CYC=8, DECAY_CYC=4, TIMEOUT_CYC=32, defaults otherwise)
//  1 Reset/idle: rst=0 with velocity=1000 -> led_on=0; release, velocity=500 valid -> led_on=16'h0000, level=0.
//  2 Sweep: velocity 521 -> 16'h0080; 700 -> 16'h00E0 (mag 200 > thr3=140, not > thr4=200); 941 -> 16'h00FF;
//    479 -> 16'h0100; 59 -> 16'hFF00; 2047 -> 16'h00FF (saturate); each 2 cycles after in_valid.
//  3 Hysteresis: 700 (level 3) then 635 -> level stays 3 (635-500=135 > thr3-HYST=130);
//    then 625 -> level 2; then 700 -> level 3 immediately.
//  4 Zero crossing: 941 (level 8, dir 1) then 400 -> level 2, dir 0, led_on=16'h0300, no intermediate pattern.
//  5 Timeout: 941 then in_valid=0 for 32 cycles -> led_on=0 on cycle 32; in_valid on cycle 32 -> no blank.
//  6 Peak (LED_BAR_PEAK_HOLD_EN): 941 then 521 -> led_on=16'h0081 for 8 cycles, then peak steps down
//    every 4 cycles to 16'h0080; undefined build -> 16'h0080 immediately.

Source files
------------

// File: rtl/led_bar_meter.sv
// led_bar_meter
//   Centre-zero LED bar graph for one joystick axis. An unsigned sample is
//   turned into a signed offset from the rest value. The offset drives a bar
//   that grows outward from the middle of the LED row: the low half of the row
//   is used above centre and the high half below it. Each lit LED needs STEP
//   more counts than the one before it. A level has to fall HYST counts below
//   its threshold before it turns off. If no valid sample arrives for
//   TIMEOUT_CYC cycles, the display blanks.
//
//   Build option: define LED_BAR_PEAK_HOLD_EN to add a peak marker. The marker
//   is one extra LED at the highest recent level. It holds for HOLD_CYC
//   cycles, then drops one step every DECAY_CYC cycles until it reaches the
//   live bar.
//
//   Timing: a sample taken on edge t updates level/dir on edge t+1 and led_on
//   on edge t+2.

module led_bar_meter #(
   parameter int unsigned IN_W        = 11,
   parameter int unsigned N_SIDE      = 8,
   parameter int unsigned CENTRE      = 500,
   parameter int unsigned DEADBAND    = 20,
   parameter int unsigned STEP        = 60,
   parameter int unsigned HYST        = 10,
   parameter int unsigned HOLD_CYC    = 50_000_000,
   parameter int unsigned DECAY_CYC   = 5_000_000,
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [IN_W-1:0]              velocity,
   output logic [2*N_SIDE-1:0]          led_on,
   output logic [$clog2(N_SIDE+1)-1:0]  level,
   output logic                         dir
);

   localparam int unsigned LV_W   = $clog2(N_SIDE + 1);
   localparam int unsigned MAG_W  = IN_W + 1;
   localparam int unsigned DIFF_W = IN_W + 2;
   localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   // A zero step or an empty bar makes the threshold ladder meaningless.
   // Zero-length peak timers cannot be counted.
   if (N_SIDE == 0 || STEP == 0 || HOLD_CYC == 0 || DECAY_CYC == 0) begin : g_bad_cfg
      $error("led_bar_meter: N_SIDE, STEP, HOLD_CYC and DECAY_CYC must be non-zero");
   end

   // Magnitude of a signed offset. It always fits one bit narrower than the
   // offset, so the result cannot wrap.
   function automatic logic [MAG_W-1:0] abs_mag(input logic signed [DIFF_W-1:0] d);
      logic signed [DIFF_W-1:0] a;
      a = (d < 0) ? -d : d;
      return a[MAG_W-1:0];
   endfunction

   // Number of LEDs whose threshold, lowered by 'hyst', the magnitude strictly
   // exceeds. A lowered threshold never goes below zero.
   function automatic logic [LV_W-1:0] count_above(input logic [MAG_W-1:0] m,
                                                   input int unsigned      hyst);
      int unsigned     thr;
      logic [LV_W-1:0] n;
      n = '0;
      for (int unsigned k = 1; k <= N_SIDE; k++) begin
         thr = DEADBAND + (k - 1) * STEP;
         thr = (thr > hyst) ? (thr - hyst) : 32'd0;
         if (32'(m) > thr) n = n + LV_W'(1);
      end
      return n;
   endfunction

   function automatic logic [LV_W-1:0] lvl_min(input logic [LV_W-1:0] a,
                                               input logic [LV_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Solid bar of n LEDs, filled outward from the centre of the row.
   function automatic logic [2*N_SIDE-1:0] bar_pattern(input logic [LV_W-1:0] n,
                                                       input logic            d);
      logic [2*N_SIDE-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < N_SIDE; i++) begin
         if (i < 32'(n)) begin
            if (d) p[N_SIDE-1-i] = 1'b1;
            else   p[N_SIDE+i]   = 1'b1;
         end
      end
      return p;
   endfunction

`ifdef LED_BAR_PEAK_HOLD_EN
   // Single LED at bar position pk (1..N_SIDE). pk = 0 lights nothing.
   function automatic logic [2*N_SIDE-1:0] peak_dot(input logic [LV_W-1:0] pk,
                                                    input logic            d);
      logic [2*N_SIDE-1:0] p;
      p = '0;
      for (int unsigned i = 1; i <= N_SIDE; i++) begin
         if (32'(pk) == i) begin
            if (d) p[N_SIDE-i]   = 1'b1;
            else   p[N_SIDE-1+i] = 1'b1;
         end
      end
      return p;
   endfunction
`endif

   // ---- stage 0: signed offset from centre (combinational) ----
   logic signed [DIFF_W-1:0] diff_p0;
   logic [MAG_W-1:0]         mag_p0;
   logic                     dir_p0;

   // Offset, magnitude and side of the incoming sample
   always_comb begin
      diff_p0 = $signed({2'b00, velocity}) - $signed(DIFF_W'(CENTRE));
      mag_p0  = abs_mag(diff_p0);
      dir_p0  = (diff_p0 > 0);
   end

   // ---- stage 1: captured sample ----
   logic             vld_p1;
   logic             dir_p1;
   logic [MAG_W-1:0] mag_p1;
   logic [LV_W-1:0]  up_p1;
   logic [LV_W-1:0]  dn_p1;
   logic [TO_W-1:0]  idle_cnt;
   logic             timeout_hit;

   // Sample qualifier; a reset drops any sample still in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p1 <= 1'b0;
      else      vld_p1 <= in_valid;
   end

   // Sample data, loaded only when qualified
   always_ff @(posedge clk) begin
      if (in_valid) begin
         dir_p1 <= dir_p0;
         mag_p1 <= mag_p0;
      end
   end

   // Rising and falling LED counts from the threshold ladder
   always_comb begin
      up_p1 = count_above(mag_p1, 0);
      dn_p1 = count_above(mag_p1, HYST);
   end

   // The terminal idle cycle blanks, unless a sample arrives on that same edge
   always_comb begin
      timeout_hit = (TIMEOUT_CYC != 0) && !in_valid && (idle_cnt == TO_LAST);
   end

   // Idle counter: cleared by every sample, parks at the terminal count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              idle_cnt <= '0;
      else if (in_valid)     idle_cnt <= '0;
      else if (!timeout_hit) idle_cnt <= idle_cnt + TO_W'(1);
   end

   // ---- stage 2: level and direction ----
   // Level update with hysteresis. A change of side resets the bar with no
   // hysteresis, so the bar never shows a stale pattern across zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= '0;
         dir   <= 1'b0;
      end else if (timeout_hit) begin
         level <= '0;
      end else if (vld_p1) begin
         if ((dir_p1 != dir) && (up_p1 != '0)) begin
            level <= up_p1;
            dir   <= dir_p1;
         end else if (up_p1 >= level) begin
            level <= up_p1;
         end else begin
            level <= lvl_min(level, dn_p1);
         end
      end
   end

   logic [2*N_SIDE-1:0] pattern_p2;

`ifdef LED_BAR_PEAK_HOLD_EN
   localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int unsigned DEC_W  = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_CYC - 1);

   logic [LV_W-1:0]   peak;
   logic              pk_dir;
   logic [HOLD_W-1:0] hold_cnt;
   logic [DEC_W-1:0]  dec_cnt;
   logic [LV_W-1:0]   pk_eff;

   // Peak tracker. A rise, a side change or a timeout snaps the peak to the
   // live level. Otherwise the peak dwells, then decays one step at a time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak     <= '0;
         pk_dir   <= 1'b0;
         hold_cnt <= '0;
         dec_cnt  <= '0;
      end else if (timeout_hit) begin
         peak     <= '0;
         hold_cnt <= '0;
         dec_cnt  <= '0;
      end else if ((dir != pk_dir) || (level >= peak)) begin
         peak     <= level;
         pk_dir   <= dir;
         hold_cnt <= '0;
         dec_cnt  <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end else if (dec_cnt != DEC_LAST) begin
         dec_cnt <= dec_cnt + DEC_W'(1);
      end else begin
         peak    <= peak - LV_W'(1);
         dec_cnt <= '0;
      end
   end

   // The peak register trails the level by one edge. Use the live level
   // whenever the peak is about to snap, so no stale marker is ever shown.
   always_comb begin
      pk_eff     = ((dir != pk_dir) || (level >= peak)) ? level : peak;
      pattern_p2 = bar_pattern(level, dir) | peak_dot(pk_eff, dir);
   end
`else
   // Plain bar
   always_comb begin
      pattern_p2 = bar_pattern(level, dir);
   end
`endif

   // ---- stage 3: LED output register ----
   // Blanked on the stale-input edge. Afterwards level stays 0, so the
   // display remains dark until the next sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             led_on <= '0;
      else if (timeout_hit) led_on <= '0;
      else                  led_on <= pattern_p2;
   end

endmodule

// File: tb/tb_led_bar_meter.sv
// Bench for led_bar_meter: directed cases with fixed expected values, then
// randomized traffic compared cycle by cycle against an arithmetic model.

module tb_led_bar_meter;

   localparam int IN_W        = 11;
   localparam int N_SIDE      = 8;
   localparam int CENTRE      = 500;
   localparam int DEADBAND    = 20;
   localparam int STEP        = 60;
   localparam int HYST        = 10;
   localparam int HOLD_CYC    = 8;
   localparam int DECAY_CYC   = 4;
   localparam int TIMEOUT_CYC = 32;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        in_valid = 1'b0;
   logic [IN_W-1:0]             velocity = '0;
   logic [2*N_SIDE-1:0]         led_on;
   logic [$clog2(N_SIDE+1)-1:0] level;
   logic                        dir;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int m_lev    = 0;
   int m_dir    = 0;
   int m_led    = 0;
   int m_idle   = 0;
   bit m_pend   = 1'b0;
   int m_pend_v = 0;

   always #5 clk = ~clk;

   led_bar_meter #(
      .IN_W(IN_W), .N_SIDE(N_SIDE), .CENTRE(CENTRE), .DEADBAND(DEADBAND),
      .STEP(STEP), .HYST(HYST), .HOLD_CYC(HOLD_CYC), .DECAY_CYC(DECAY_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .velocity(velocity),
      .led_on(led_on), .level(level), .dir(dir)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // LEDs lit for magnitude m: threshold k is DEADBAND+(k-1)*STEP, strict >
   function automatic int ref_lit(input int m);
      int c;
      if (m <= DEADBAND) return 0;
      c = (m - DEADBAND - 1) / STEP + 1;
      return (c > N_SIDE) ? N_SIDE : c;
   endfunction

   function automatic int ref_bar(input int l, input int d);
      int ones;
      ones = (1 << l) - 1;
      return (d != 0) ? (ones << (N_SIDE - l)) : (ones << N_SIDE);
   endfunction

   // One clock of the model, evaluated with the inputs applied on that edge
   task automatic model_step(input bit iv, input int v);
      int mag, d, up, dn, nled;
      bit blank;
      m_idle = iv ? 0 : m_idle + 1;
      blank  = (TIMEOUT_CYC != 0) && (m_idle >= TIMEOUT_CYC);
      nled   = blank ? 0 : ref_bar(m_lev, m_dir);
      if (blank) begin
         m_lev = 0;
      end else if (m_pend) begin
         mag = m_pend_v - CENTRE;
         d   = (mag > 0) ? 1 : 0;
         if (mag < 0) mag = -mag;
         up  = ref_lit(mag);
         dn  = (mag == 0) ? 0 : ref_lit(mag + HYST);
         if (d != m_dir && up > 0) begin
            m_lev = up;
            m_dir = d;
         end else if (up >= m_lev) begin
            m_lev = up;
         end else begin
            m_lev = (m_lev < dn) ? m_lev : dn;
         end
      end
      m_pend   = iv;
      m_pend_v = v;
      m_led    = nled;
   endtask

   // Starts and ends at a negedge: drive, clock once, advance the model
   task automatic cyc(input bit iv, input int v);
      in_valid = iv;
      velocity = IN_W'(v);
      @(posedge clk);
      model_step(iv, v);
      @(negedge clk);
   endtask

   // Sample on one edge, then two idle edges so led_on reflects it
   task automatic send(input int v);
      cyc(1'b1, v);
      cyc(1'b0, v);
      cyc(1'b0, v);
   endtask

   task automatic expect_out(input string tag, input int lv, input int dr, input int led);
      check({tag, "_level"}, int'(level), lv);
      check({tag, "_dir"}, int'(dir), dr);
      check({tag, "_led"}, int'(led_on), led);
   endtask

   initial begin
      bit reached;
      int burst;
      bit iv;
      int v;

      // 1: reset holds everything dark even with a far-off valid sample
      rst      = 1'b0;
      in_valid = 1'b1;
      velocity = IN_W'(1000);
      repeat (3) @(negedge clk);
      expect_out("reset", 0, 0, 'h0000);
      rst      = 1'b1;
      in_valid = 1'b0;
      send(500);
      expect_out("idle_centre", 0, 0, 'h0000);

      // 2: sweep across both sides including saturation
      send(521);  expect_out("sweep521", 1, 1, 'h0080);
      send(700);  expect_out("sweep700", 3, 1, 'h00E0);
      send(941);  expect_out("sweep941", 8, 1, 'h00FF);
      send(479);  expect_out("sweep479", 1, 0, 'h0100);
      send(59);   expect_out("sweep59", 8, 0, 'hFF00);
      send(2047); expect_out("sweep2047", 8, 1, 'h00FF);

      // 3: hysteresis (centre first so the bar starts from zero)
      send(500); check("hyst_clear", int'(level), 0);
      send(700); check("hyst_700", int'(level), 3);
      send(635); check("hyst_635_hold", int'(level), 3);
      send(625); check("hyst_625_fall", int'(level), 2);
      send(700); check("hyst_700_rise", int'(level), 3);

      // 4: zero crossing jumps straight to the new side
      send(941);
      check("cross_941", int'(level), 8);
      cyc(1'b1, 400);
      cyc(1'b0, 400);
      check("cross_mid_led", int'(led_on), 'h00FF);
      cyc(1'b0, 400);
      expect_out("cross_400", 2, 0, 'h0300);

      // Boundaries: magnitude equal to a threshold does not light that LED
      send(500); check("bnd_500", int'(level), 0);
      send(520); expect_out("bnd_deadband", 0, 0, 'h0000);
      send(580); expect_out("bnd_thr2", 1, 1, 'h0080);
      send(581); expect_out("bnd_thr2p1", 2, 1, 'h00C0);

      // 5: timeout blanks on the 32nd idle cycle
      send(941);
      repeat (TIMEOUT_CYC - 3) cyc(1'b0, 941);
      expect_out("pre_timeout", 8, 1, 'h00FF);
      cyc(1'b0, 941);
      check("timeout_led", int'(led_on), 'h0000);
      check("timeout_level", int'(level), 0);
      // A sample on the terminal cycle wins over the timeout
      send(941);
      repeat (TIMEOUT_CYC - 3) cyc(1'b0, 941);
      cyc(1'b1, 941);
      check("rescue_led", int'(led_on), 'h00FF);
      cyc(1'b0, 941);
      expect_out("rescue_after", 8, 1, 'h00FF);

      // 6: peak hold
      send(941);
      send(521);
      check("peak_level", int'(level), 1);
`ifdef LED_BAR_PEAK_HOLD_EN
      check("peak_hold", int'(led_on), 'h0081);
      reached = 1'b0;
      for (int i = 0; i < 80 && !reached; i++) begin
         cyc(1'b1, 521);
         if (led_on == 16'h0080) reached = 1'b1;
      end
      check("peak_decayed", int'(reached), 1);
`else
      check("no_peak", int'(led_on), 'h0080);
`endif

      // Randomized traffic with occasional long idle bursts
      burst = 0;
      for (int i = 0; i < 800; i++) begin
         if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(30, 40);
         if (burst > 0) begin
            iv = 1'b0;
            burst--;
         end else begin
            iv = ($urandom_range(0, 3) != 0);
         end
         v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(300, 700))
                                          : int'($urandom_range(0, 2047));
         cyc(iv, v);
         check("rnd_level", int'(level), m_lev);
         check("rnd_dir", int'(dir), m_dir);
`ifndef LED_BAR_PEAK_HOLD_EN
         check("rnd_led", int'(led_on), m_led);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
